// File: rtl/npu_host_seq.sv
// npu_host_seq
// Bus-initiator sequencer for the NPU's 32-bit memory-mapped host port.
// For every output pixel it writes K_W weight columns and K_W image columns
// taken from the source stream, fires the trigger, polls the valid flag,
// reads the result and forwards it on the result stream.
//
// Optional feature: define NPU_HOST_SEQ_POLL_TIMEOUT_EN to compile in the
// poll counter. After POLL_MAX consecutive "not valid" reads the sequencer
// sets err, abandons the remaining pixels and finishes (no next-state write).
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start_i                  start pulse, accepted only when idle
//   num_pix_i                pixel count, sampled on start (0 = none)
//   adv_stage_i              sampled on start; issue next-state write at end
//   busy_o / done_o / err_o  status: not idle / completion pulse / timeout
//   s_valid_i/s_ready_o/s_data_i    source stream (three packed 8-bit lanes)
//   m_valid_o/m_ready_i/m_data_o    result stream
//   npu_ena_o/npu_wea_o/npu_addra_o/npu_dina_o/npu_douta_i   NPU host port
module npu_host_seq #(
    parameter int K_W      = 3,
    parameter int POLL_MAX = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [15:0] num_pix_i,
    input  logic        adv_stage_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [23:0] s_data_i,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic [31:0] m_data_o,
    output logic        npu_ena_o,
    output logic        npu_wea_o,
    output logic [15:0] npu_addra_o,
    output logic [31:0] npu_dina_o,
    input  logic [31:0] npu_douta_i
);
    localparam int            BW        = (K_W > 1) ? $clog2(K_W) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(K_W - 1);

    localparam logic [2:0] SEL_IMG = 3'b001;
    localparam logic [2:0] SEL_WGT = 3'b010;
    localparam logic [2:0] SEL_CTL = 3'b100;
    localparam logic [2:0] SEL_RES = 3'b110;
    localparam logic [2:0] SEL_VLD = 3'b111;

    // Control word: [0] trigger, [1] next-state, [5:2] clears
    localparam logic [31:0] CTL_CLEAR = 32'h0000_003C;
    localparam logic [31:0] CTL_TRIG  = 32'h0000_0001;
    localparam logic [31:0] CTL_NEXT  = 32'h0000_0002;

    typedef enum logic [3:0] {
        IDLE, CLR, LD_W, LD_IMG, TRIG, POLL_REQ, POLL_WAIT,
        RD_REQ, RD_WAIT, OUT, ADV, DONE
    } state_t;

    state_t        state_q;
    logic [BW-1:0] beat_q;
    logic [15:0]   pix_q;
    logic          adv_q;
    logic          m_valid_q;
    logic [31:0]   m_data_q;
    logic [2:0]    sel_d;
    logic          poll_expire_d;

`ifdef NPU_HOST_SEQ_POLL_TIMEOUT_EN
    localparam int            PW        = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

    logic [PW-1:0] poll_q;
    logic          err_q;

    // This read is the POLL_MAX-th consecutive "not valid" answer
    assign poll_expire_d = !npu_douta_i[0] && (poll_q == POLL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poll_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && start_i) begin
                err_q <= 1'b0;
            end else if (state_q == POLL_WAIT && poll_expire_d) begin
                err_q <= 1'b1;
            end
            if (state_q == TRIG) begin
                poll_q <= '0;
            end else if (state_q == POLL_WAIT && !npu_douta_i[0]) begin
                poll_q <= poll_q + 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    // Polling is unbounded in this build; POLL_MAX has no effect.
    logic unused_poll_max;
    assign unused_poll_max = (POLL_MAX > 0);
    assign poll_expire_d   = 1'b0;
    assign err_o           = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            pix_q     <= '0;
            adv_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    pix_q   <= num_pix_i;
                    adv_q   <= adv_stage_i;
                    beat_q  <= '0;
                    state_q <= CLR;
                end
                CLR: begin
                    if (pix_q != 16'd0) state_q <= LD_W;
                    else if (adv_q)     state_q <= ADV;
                    else                state_q <= DONE;
                end
                LD_W: if (s_valid_i) begin
                    if (beat_q == BEAT_LAST) begin
                        beat_q  <= '0;
                        state_q <= LD_IMG;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                LD_IMG: if (s_valid_i) begin
                    if (beat_q == BEAT_LAST) begin
                        beat_q  <= '0;
                        state_q <= TRIG;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                TRIG:     state_q <= POLL_REQ;
                POLL_REQ: state_q <= POLL_WAIT;
                // npu_douta_i holds the answer to last cycle's valid read
                POLL_WAIT: begin
                    if (npu_douta_i[0])     state_q <= RD_REQ;
                    else if (poll_expire_d) state_q <= DONE;
                    else                    state_q <= POLL_REQ;
                end
                RD_REQ: state_q <= RD_WAIT;
                RD_WAIT: begin
                    m_data_q  <= npu_douta_i;
                    m_valid_q <= 1'b1;
                    state_q   <= OUT;
                end
                OUT: if (m_ready_i) begin
                    m_valid_q <= 1'b0;
                    pix_q     <= pix_q - 16'd1;
                    if (pix_q != 16'd1) state_q <= LD_W;
                    else if (adv_q)     state_q <= ADV;
                    else                state_q <= DONE;
                end
                ADV:     state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Bus decode; load cycles only issue a write on an accepted source beat
    always_comb begin
        npu_ena_o  = 1'b0;
        npu_wea_o  = 1'b0;
        sel_d      = 3'b000;
        npu_dina_o = '0;
        case (state_q)
            CLR: begin
                npu_ena_o = 1'b1; npu_wea_o = 1'b1; sel_d = SEL_CTL; npu_dina_o = CTL_CLEAR;
            end
            LD_W: if (s_valid_i) begin
                npu_ena_o = 1'b1; npu_wea_o = 1'b1; sel_d = SEL_WGT; npu_dina_o = {8'h00, s_data_i};
            end
            LD_IMG: if (s_valid_i) begin
                npu_ena_o = 1'b1; npu_wea_o = 1'b1; sel_d = SEL_IMG; npu_dina_o = {8'h00, s_data_i};
            end
            TRIG: begin
                npu_ena_o = 1'b1; npu_wea_o = 1'b1; sel_d = SEL_CTL; npu_dina_o = CTL_TRIG;
            end
            POLL_REQ: begin
                npu_ena_o = 1'b1; sel_d = SEL_VLD;
            end
            RD_REQ: begin
                npu_ena_o = 1'b1; sel_d = SEL_RES;
            end
            ADV: begin
                npu_ena_o = 1'b1; npu_wea_o = 1'b1; sel_d = SEL_CTL; npu_dina_o = CTL_NEXT;
            end
            default: ;
        endcase
    end

    assign npu_addra_o = {1'b0, sel_d, 12'h000};
    assign s_ready_o   = (state_q == LD_W) || (state_q == LD_IMG);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign m_valid_o   = m_valid_q;
    assign m_data_o    = m_data_q;

endmodule
